// File: rtl/trig_pkg.sv
// Shared definitions for the trigger/capture controller: channel trigger modes
// and capture FSM state encoding.
package trig_pkg;

  localparam logic [2:0] TRIG_OFF  = 3'd0;
  localparam logic [2:0] TRIG_RISE = 3'd1;
  localparam logic [2:0] TRIG_FALL = 3'd2;
  localparam logic [2:0] TRIG_ANY  = 3'd3;
  localparam logic [2:0] TRIG_HIGH = 3'd4;
  localparam logic [2:0] TRIG_LOW  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_e;

endpackage

// File: rtl/trig_ch_match.sv
// Single-channel trigger decode: reports whether the channel takes part in the
// trigger and whether its edge/level condition holds this cycle.
module trig_ch_match
  import trig_pkg::*;
(
  input  logic [2:0] mode,
  input  logic       cur,
  input  logic       prev,
  input  logic       prev_valid,
  output logic       enabled,
  output logic       match
);

  always_comb begin
    enabled = 1'b1;
    match   = 1'b0;
    case (mode)
      TRIG_RISE: match = prev_valid & ~prev & cur;
      TRIG_FALL: match = prev_valid & prev & ~cur;
      TRIG_ANY:  match = prev_valid & (prev ^ cur);
      TRIG_HIGH: match = cur;
      TRIG_LOW:  match = ~cur;
      TRIG_OFF:  enabled = 1'b0;
      default:   enabled = 1'b0;
    endcase
  end

endmodule

// File: rtl/trig_capture_ctrl.sv
// Multi-channel trigger and capture controller: pre-fill, wait for the combined
// trigger, then write a programmable number of post-trigger samples.
module trig_capture_ctrl
  import trig_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned PRE_SAMPLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   data,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [3*CHANNELS-1:0] ch_mode,
  input  logic                  combine,
  input  logic [CNT_W-1:0]      post_count,
  input  logic                  write_finish,
  output logic                  we,
  output logic                  triggered,
  output logic [CHANNELS-1:0]   trig_ch,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_W-1:0] PreLast = CNT_W'(PRE_SAMPLES - 1);

  state_e                  state_q;
  logic [3*CHANNELS-1:0]   mode_q;
  logic                    combine_q;
  logic [CNT_W-1:0]        post_count_q;
  logic [CNT_W-1:0]        pre_cnt_q;
  logic [CNT_W-1:0]        post_cnt_q;
  logic [CHANNELS-1:0]     prev_q;
  logic                    prev_valid_q;
  logic [CHANNELS-1:0]     en;
  logic [CHANNELS-1:0]     match;
  logic                    fire;
  logic                    arm_ok;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    trig_ch_match u_match (
      .mode       (mode_q[3*i +: 3]),
      .cur        (data[i]),
      .prev       (prev_q[i]),
      .prev_valid (prev_valid_q),
      .enabled    (en[i]),
      .match      (match[i])
    );
  end

  // With nothing enabled, neither OR nor AND may ever fire.
  assign fire = combine_q ? ((|en) & (&(match | ~en))) : (|(match & en));

  assign arm_ok = arm & ~abort & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign busy   = (state_q == S_PRE) | (state_q == S_WAIT) | (state_q == S_POST);
  assign we     = busy;
  assign done   = (state_q == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      combine_q    <= 1'b0;
      post_count_q <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      triggered    <= 1'b0;
      trig_ch      <= '0;
    end else begin
      prev_q       <= data;
      prev_valid_q <= ~arm_ok;
      if (abort) begin
        state_q   <= S_IDLE;
        triggered <= 1'b0;
        trig_ch   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE: begin
            if (arm) begin
              mode_q       <= ch_mode;
              combine_q    <= combine;
              post_count_q <= post_count;
              pre_cnt_q    <= '0;
              triggered    <= 1'b0;
              trig_ch      <= '0;
              state_q      <= (PRE_SAMPLES == 0) ? S_WAIT : S_PRE;
            end
          end
          S_PRE: begin
            if (write_finish)           state_q   <= S_DONE;
            else if (pre_cnt_q == PreLast) state_q <= S_WAIT;
            else                        pre_cnt_q <= pre_cnt_q + CNT_W'(1);
          end
          S_WAIT: begin
            if (write_finish) begin
              state_q <= S_DONE;
            end else if (fire) begin
              triggered  <= 1'b1;
              trig_ch    <= match;
              post_cnt_q <= '0;
              state_q    <= (post_count_q == '0) ? S_DONE : S_POST;
            end
          end
          S_POST: begin
            if (write_finish)                               state_q <= S_DONE;
            else if (post_cnt_q + CNT_W'(1) == post_count_q) state_q <= S_DONE;
            else                                            post_cnt_q <= post_cnt_q + CNT_W'(1);
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Bench for trig_capture_ctrl: directed tables and sequences plus randomized
// stimulus checked every cycle against a counter-based behavioural model.
module tb_trig_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  data;
  logic        arm, abort, combine, write_finish;
  logic [11:0] ch_mode, post_count;

  logic       we_a, trig_a, busy_a, done_a;
  logic [3:0] tch_a;
  logic       we_b, trig_b, busy_b, done_b;
  logic [3:0] tch_b;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  trig_capture_ctrl #(.CHANNELS(4), .CNT_W(12), .PRE_SAMPLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .data(data), .arm(arm), .abort(abort),
    .ch_mode(ch_mode), .combine(combine), .post_count(post_count),
    .write_finish(write_finish), .we(we_a), .triggered(trig_a), .trig_ch(tch_a),
    .busy(busy_a), .done(done_a)
  );

  trig_capture_ctrl #(.CHANNELS(4), .CNT_W(12), .PRE_SAMPLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .data(data), .arm(arm), .abort(abort),
    .ch_mode(ch_mode), .combine(combine), .post_count(post_count),
    .write_finish(write_finish), .we(we_b), .triggered(trig_b), .trig_ch(tch_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 mirrors dut (4 pre samples), index 1 mirrors dut0.
  bit          m_act[2], m_done[2], m_trig[2], m_pv[2], m_comb[2];
  int          m_pre[2], m_post[2], m_pc[2];
  logic [3:0]  m_tch[2], m_prev[2];
  logic [11:0] m_mode[2];

  function automatic bit ch_hit(int m, bit p, bit d, bit pv);
    case (m)
      1: return pv && !p && d;
      2: return pv && p && !d;
      3: return pv && (p != d);
      4: return d;
      5: return !d;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(int k, int pre);
    logic [3:0] hits;
    int n_en, n_hit;
    bit fire, arm_acc;
    hits = '0; n_en = 0; n_hit = 0;
    for (int c = 0; c < 4; c++) begin
      int m;
      m = int'(m_mode[k][3*c +: 3]);
      if (m >= 1 && m <= 5) begin
        n_en++;
        hits[c] = ch_hit(m, m_prev[k][c], data[c], m_pv[k]);
        if (hits[c]) n_hit++;
      end
    end
    fire    = (n_en > 0) && (m_comb[k] ? (n_hit == n_en) : (n_hit > 0));
    arm_acc = arm && !abort && !m_act[k];
    if (abort) begin
      m_act[k] = 0; m_done[k] = 0; m_trig[k] = 0; m_tch[k] = '0;
    end else if (m_act[k]) begin
      if (write_finish) begin
        m_act[k] = 0; m_done[k] = 1;
      end else if (m_pre[k] > 0) begin
        m_pre[k]--;
      end else if (m_post[k] < 0) begin
        if (fire) begin
          m_trig[k] = 1; m_tch[k] = hits;
          if (m_pc[k] == 0) begin m_act[k] = 0; m_done[k] = 1; end
          else m_post[k] = m_pc[k];
        end
      end else begin
        m_post[k]--;
        if (m_post[k] == 0) begin m_act[k] = 0; m_done[k] = 1; end
      end
    end else if (arm) begin
      m_act[k] = 1; m_done[k] = 0; m_trig[k] = 0; m_tch[k] = '0;
      m_pre[k] = pre; m_post[k] = -1;
      m_mode[k] = ch_mode; m_comb[k] = combine; m_pc[k] = int'(post_count);
    end
    m_pv[k]   = !arm_acc;
    m_prev[k] = data;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0; m_done[k] = 0; m_trig[k] = 0; m_pv[k] = 0; m_comb[k] = 0;
        m_pre[k] = 0; m_post[k] = -1; m_pc[k] = 0; m_tch[k] = '0; m_prev[k] = '0;
        m_mode[k] = '0;
      end
    end else begin
      model_step(0, 4);
      model_step(1, 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_pre4", {24'd0, we_a, busy_a, trig_a, done_a, tch_a},
          {24'd0, m_act[0], m_act[0], m_trig[0], m_done[0], m_tch[0]});
      chk("model_pre0", {24'd0, we_b, busy_b, trig_b, done_b, tch_b},
          {24'd0, m_act[1], m_act[1], m_trig[1], m_done[1], m_tch[1]});
    end
  end

  typedef struct {
    logic        arm, abort, wf;
    logic [3:0]  data;
    logic [11:0] mode;
    logic        comb;
    logic [11:0] pc;
    logic        e_we, e_trig, e_done;
    logic [3:0]  e_tch;
  } vec_t;

  function automatic vec_t mk(logic a, logic ab, logic [3:0] d, logic [11:0] md, logic cb,
                              logic [11:0] pc, logic ew, logic et, logic ed, logic [3:0] etc);
    vec_t v;
    v.arm = a; v.abort = ab; v.wf = 1'b0; v.data = d; v.mode = md; v.comb = cb; v.pc = pc;
    v.e_we = ew; v.e_trig = et; v.e_done = ed; v.e_tch = etc;
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  vec_t tbl[22];

  initial begin
    // OR, ch0 rising, post 2; config inputs zeroed after arm to prove latching
    tbl[0]  = mk(1, 0, 4'b0000, 12'h001, 0, 12'd2, 0, 0, 0, 4'b0000);
    tbl[1]  = mk(0, 0, 4'b0000, 12'h000, 0, 12'd0, 1, 0, 0, 4'b0000);
    tbl[2]  = mk(0, 0, 4'b0001, 12'h000, 0, 12'd0, 1, 0, 0, 4'b0000);
    tbl[3]  = mk(0, 0, 4'b0000, 12'h000, 0, 12'd0, 1, 0, 0, 4'b0000);
    tbl[4]  = mk(0, 0, 4'b0000, 12'h000, 0, 12'd0, 1, 0, 0, 4'b0000);
    tbl[5]  = mk(0, 0, 4'b0000, 12'h000, 0, 12'd0, 1, 0, 0, 4'b0000);
    tbl[6]  = mk(0, 0, 4'b0001, 12'h000, 0, 12'd0, 1, 0, 0, 4'b0000);
    tbl[7]  = mk(0, 0, 4'b0001, 12'h000, 0, 12'd0, 1, 1, 0, 4'b0001);
    tbl[8]  = mk(0, 0, 4'b0000, 12'h000, 0, 12'd0, 1, 1, 0, 4'b0001);
    tbl[9]  = mk(0, 1, 4'b0000, 12'h000, 0, 12'd0, 0, 1, 1, 4'b0001);
    tbl[10] = mk(0, 0, 4'b0000, 12'h000, 0, 12'd0, 0, 0, 0, 4'b0000);
    // AND: ch1 level high, ch2 falling, post 1
    tbl[11] = mk(1, 0, 4'b0000, 12'h0A0, 1, 12'd1, 0, 0, 0, 4'b0000);
    tbl[12] = mk(0, 0, 4'b0110, 12'h000, 0, 12'd0, 1, 0, 0, 4'b0000);
    tbl[13] = mk(0, 0, 4'b0110, 12'h000, 0, 12'd0, 1, 0, 0, 4'b0000);
    tbl[14] = mk(0, 0, 4'b0110, 12'h000, 0, 12'd0, 1, 0, 0, 4'b0000);
    tbl[15] = mk(0, 0, 4'b0110, 12'h000, 0, 12'd0, 1, 0, 0, 4'b0000);
    tbl[16] = mk(0, 0, 4'b0000, 12'h000, 0, 12'd0, 1, 0, 0, 4'b0000);
    tbl[17] = mk(0, 0, 4'b0110, 12'h000, 0, 12'd0, 1, 0, 0, 4'b0000);
    tbl[18] = mk(0, 0, 4'b0010, 12'h000, 0, 12'd0, 1, 0, 0, 4'b0000);
    tbl[19] = mk(0, 0, 4'b0010, 12'h000, 0, 12'd0, 1, 1, 0, 4'b0110);
    tbl[20] = mk(0, 1, 4'b0000, 12'h000, 0, 12'd0, 0, 1, 1, 4'b0110);
    tbl[21] = mk(0, 0, 4'b0000, 12'h000, 0, 12'd0, 0, 0, 0, 4'b0000);

    reset_n = 1'b0; data = '0; arm = 0; abort = 0; combine = 0; write_finish = 0;
    ch_mode = '0; post_count = '0;
    repeat (3) tick();
    chk("reset_pre4", {24'd0, we_a, busy_a, trig_a, done_a, tch_a}, 32'd0);
    chk("reset_pre0", {24'd0, we_b, busy_b, trig_b, done_b, tch_b}, 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    tick();

    for (int i = 0; i < 22; i++) begin
      chk($sformatf("tbl%0d_we", i), {31'd0, we_a}, {31'd0, tbl[i].e_we});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy_a}, {31'd0, tbl[i].e_we});
      chk($sformatf("tbl%0d_trig", i), {31'd0, trig_a}, {31'd0, tbl[i].e_trig});
      chk($sformatf("tbl%0d_done", i), {31'd0, done_a}, {31'd0, tbl[i].e_done});
      chk($sformatf("tbl%0d_tch", i), {28'd0, tch_a}, {28'd0, tbl[i].e_tch});
      arm = tbl[i].arm; abort = tbl[i].abort; write_finish = tbl[i].wf; data = tbl[i].data;
      ch_mode = tbl[i].mode; combine = tbl[i].comb; post_count = tbl[i].pc;
      tick();
    end

    // All channels disabled: must sit in WAIT writing until memory is full
    abort = 1; tick(); abort = 0;
    arm = 1; ch_mode = '0; combine = 0; post_count = 12'd5; tick(); arm = 0;
    for (int i = 0; i < 1004; i++) begin
      data = 4'($urandom);
      tick();
    end
    chk("off_wait_we", {31'd0, we_a}, 32'd1);
    chk("off_wait_trig", {31'd0, trig_a}, 32'd0);
    write_finish = 1; tick(); write_finish = 0;
    chk("off_wf_done", {31'd0, done_a}, 32'd1);
    chk("off_wf_trig", {31'd0, trig_a}, 32'd0);
    chk("off_wf_we", {31'd0, we_a}, 32'd0);

    // No pre-fill: the first cycle after arm must not see an edge
    abort = 1; data = '0; tick(); abort = 0;
    arm = 1; ch_mode = 12'h001; combine = 0; post_count = 12'd1; data = 4'b0000; tick();
    arm = 0; data = 4'b0001; tick();
    chk("pv_first_trig", {31'd0, trig_b}, 32'd0);
    chk("pv_first_we", {31'd0, we_b}, 32'd1);
    data = 4'b0001; tick();
    data = 4'b0000; tick();
    data = 4'b0001; tick();
    chk("pv_later_trig", {31'd0, trig_b}, 32'd1);
    chk("pv_later_tch", {28'd0, tch_b}, 32'd1);

    // Abort mid-POST after 20 post-trigger samples
    abort = 1; tick(); abort = 0;
    arm = 1; ch_mode = 12'h004; post_count = 12'd100; data = 4'b0001; tick(); arm = 0;
    repeat (4) tick();
    repeat (20) tick();
    chk("post_trig", {31'd0, trig_a}, 32'd1);
    chk("post_we", {31'd0, we_a}, 32'd1);
    abort = 1; tick(); abort = 0;
    chk("abort_out", {24'd0, we_a, busy_a, trig_a, done_a, tch_a}, 32'd0);

    // Asynchronous reset mid-WAIT
    arm = 1; ch_mode = '0; data = '0; tick(); arm = 0;
    repeat (6) tick();
    chk("wait_we", {31'd0, we_a}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_pre4", {24'd0, we_a, busy_a, trig_a, done_a, tch_a}, 32'd0);
    chk("async_rst_pre0", {24'd0, we_b, busy_b, trig_b, done_b, tch_b}, 32'd0);
    tick(); reset_n = 1'b1; tick();

    // post_count 0: trigger and write_finish together -> one write, untriggered
    arm = 1; ch_mode = 12'h004; post_count = 12'd0; data = 4'b0001; tick(); arm = 0;
    chk("pc0_we", {31'd0, we_b}, 32'd1);
    write_finish = 1; tick(); write_finish = 0;
    chk("pc0_done", {31'd0, done_b}, 32'd1);
    chk("pc0_trig", {31'd0, trig_b}, 32'd0);
    chk("pc0_we_after", {31'd0, we_b}, 32'd0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      arm          = ($urandom_range(0, 11) == 0);
      abort        = ($urandom_range(0, 79) == 0);
      write_finish = ($urandom_range(0, 39) == 0);
      data         = 4'($urandom);
      ch_mode      = 12'($urandom);
      combine      = 1'($urandom);
      post_count   = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 40))
                                                 : 12'($urandom_range(0, 6));
      tick();
    end
    arm = 0; abort = 0; write_finish = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trig_capture_ctrl.md
Name: trig_capture_ctrl

Overview:
Parametrised multi-channel trigger and capture controller for the logic-analyzer data path; the generalised successor of the single-channel edge detector. Each channel gets a per-channel trigger condition (edge or level), combined by AND/OR, with a pre-trigger fill phase and a programmable post-trigger sample count. Drives the sample-memory write enable and reports trigger and done status to the control/UART side.

Parameters:
CHANNELS, 4, number of sampled input channels.
CNT_W, 12, width of the post-trigger and pre-trigger counters.
PRE_SAMPLES, 16, samples written unconditionally before triggering is enabled (0 = no pre-fill phase).

Ports:
clk  in  1  sampling clock.
reset_n  in  1  asynchronous, active-low reset.
data  in  CHANNELS  sampled channel inputs, already synchronous to clk.
arm  in  1  single-cycle pulse; latches config and starts capture.
abort  in  1  single-cycle pulse; returns to IDLE.
ch_mode  in  3*CHANNELS  per-channel trigger mode; channel i occupies bits [3i+2:3i].
combine  in  1  0 = OR of enabled channels, 1 = AND of enabled channels.
post_count  in  CNT_W  samples written after the trigger sample.
write_finish  in  1  memory full; ends capture early.
we  out  1  sample-memory write enable.
triggered  out  1  high from the trigger cycle until the next arm, abort or reset.
trig_ch  out  CHANNELS  per-channel match vector captured on the trigger cycle.
busy  out  1  high in PRE, WAIT and POST.
done  out  1  high in DONE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; we, triggered, busy and done = 0; trig_ch=0; counters=0; prev=0; prev_valid=0.
- Mode encoding: 0 disabled; 1 rising; 2 falling; 3 any edge; 4 level high; 5 level low; 6 and 7 treated as disabled.
- Config latch: ch_mode, combine and post_count are registered on the arm cycle. Later changes to these inputs have no effect until the next arm.
- Edge detection:
  - prev<=data every cycle; prev_valid cleared on arm, set the following cycle.
  - Edge matches are suppressed while prev_valid=0. Level matches do not depend on prev_valid.
- Combining:
  - OR fires if any enabled channel matches.
  - AND fires if every enabled channel matches in the same cycle.
  - If all channels are disabled, the trigger never fires in either mode.
- States:
  - IDLE: we=0. arm -> PRE, or -> WAIT if PRE_SAMPLES=0. The pre counter is cleared.
  - PRE: we=1. Trigger conditions are ignored. After PRE_SAMPLES write cycles -> WAIT.
  - WAIT: we=1. On a trigger-condition cycle: that sample is written, triggered<=1, trig_ch<=match vector, post counter cleared. Then -> POST, or -> DONE if latched post_count=0.
  - POST: we=1. After exactly post_count further write cycles -> DONE.
  - DONE: we=0, done=1. arm -> re-arm (same as from IDLE); abort -> IDLE.
- write_finish:
  - In PRE, WAIT or POST: the current cycle's write still occurs. Next state is DONE; triggered keeps its current value.
  - Ignored in IDLE and DONE.
- abort: highest priority after reset. From any state -> IDLE next cycle; triggered and trig_ch cleared.
- arm while busy: ignored.
- Simultaneous events in the same cycle: abort beats write_finish, which beats trigger.
- Outputs:
  - we and busy are decoded combinationally from state, with no extra latency.
  - The trigger sample's we is in the same cycle the condition is seen.
- Counters: saturating compare with ==, no wrap-around. post_count = 2^CNT_W-1 is legal.

Decomposition:
- Shared package trig_pkg: mode localparams (TRIG_OFF, TRIG_RISE, TRIG_FALL, TRIG_ANY, TRIG_HIGH, TRIG_LOW); state encoding (S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE).
- One sub-module, trig_ch_match: a single channel's mode decode plus edge/level match, instantiated CHANNELS times via generate.
- The FSM and counters stay in the top module.

Test Plan:
- PRE_SAMPLES=4, ch0 rising, OR, post_count=3; data[0] 0->1 at cycle 10 after arm -> we high 4 (pre) + wait cycles + 1 + 3; triggered=1; trig_ch=4'b0001; done=1.
- AND: ch1 level high, ch2 falling; ch1=1 with no ch2 fall -> no trigger; then ch2 1->0 while ch1=1 -> trigger that cycle; trig_ch=4'b0110.
- All ch_mode=0, OR -> stays in WAIT with we=1 for 1000 cycles; no trigger; write_finish -> DONE, triggered=0.
- data[0]=1 already at arm, rising mode, PRE_SAMPLES=0 -> no trigger on the first cycle; a later 0->1 does trigger.
- abort asserted mid-POST (post_count=100, after 20 samples) -> IDLE next cycle; we=0, triggered=0. Async reset_n low mid-WAIT -> all outputs 0 immediately.
- post_count=0 with trigger and write_finish asserted in the same cycle -> one write, then DONE; triggered=0 (write_finish wins).
